// File: rtl/traffic_ctrl.sv
// Timed two-road intersection controller: road 1 rests on green, road 2 served on latched sensor demand.
// Optional night-flash mode is built when TRAFFIC_FLASH_EN is defined (adds the flash input and FLASH state).
`timescale 1ns/1ps
module traffic_ctrl #(
  parameter int TICK_DIV = 4,
  parameter int TW       = 8,
  parameter int GREEN1_T = 3,
  parameter int GREEN2_T = 2,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s2,
`ifdef TRAFFIC_FLASH_EN
  input  logic       flash,
`endif
  output logic       g1,
  output logic       y1,
  output logic       r1,
  output logic       g2,
  output logic       y2,
  output logic       r2,
  output logic [2:0] phase,
  output logic       req_pend
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] LD_G1 = TW'(GREEN1_T - 1);
  localparam logic [TW-1:0] LD_G2 = TW'(GREEN2_T - 1);
  localparam logic [TW-1:0] LD_Y  = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] LD_AR = TW'(ALLRED_T - 1);

  typedef enum logic [2:0] {
    S_G1   = 3'd0,
    S_Y1   = 3'd1,
    S_AR12 = 3'd2,
    S_G2   = 3'd3,
    S_Y2   = 3'd4,
`ifdef TRAFFIC_FLASH_EN
    S_AR21 = 3'd5,
    S_FLASH = 3'd6
`else
    S_AR21 = 3'd5
`endif
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [PW-1:0]   r_presc;
  logic [TW-1:0]   r_timer;
  logic [5:0]      r_lamps;
  logic            r_req;
  logic            r_g1_min;
  logic            w_tick;
  logic            w_expired;
  logic            w_chg;

  // Lamp vector order: {g1, y1, r1, g2, y2, r2}
  function automatic logic [5:0] lamps_of(input state_t s);
    case (s)
      S_G1:    lamps_of = 6'b100_001;
      S_Y1:    lamps_of = 6'b010_001;
      S_G2:    lamps_of = 6'b001_100;
      S_Y2:    lamps_of = 6'b001_010;
`ifdef TRAFFIC_FLASH_EN
      S_FLASH: lamps_of = 6'b010_001;
`endif
      default: lamps_of = 6'b001_001;
    endcase
  endfunction

  function automatic logic [TW-1:0] load_of(input state_t s);
    case (s)
      S_G1:       load_of = LD_G1;
      S_G2:       load_of = LD_G2;
      S_Y1, S_Y2: load_of = LD_Y;
      default:    load_of = LD_AR;
    endcase
  endfunction

  assign w_tick    = (r_presc == PRESC_MAX);
  assign w_expired = (r_timer == '0) && w_tick;
  assign w_chg     = (w_nxt != r_state);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_AR21: if (w_expired) w_nxt = S_G1;
      // Minimum green may already be over; then demand alone moves us on
      S_G1:   if ((r_g1_min || w_expired) && r_req) w_nxt = S_Y1;
      S_Y1:   if (w_expired) w_nxt = S_AR12;
      S_AR12: if (w_expired) w_nxt = S_G2;
      S_G2:   if (w_expired) w_nxt = S_Y2;
      S_Y2:   if (w_expired) w_nxt = S_AR21;
`ifdef TRAFFIC_FLASH_EN
      S_FLASH: if (!flash) w_nxt = S_AR21;
`endif
      default: w_nxt = S_AR21;
    endcase
`ifdef TRAFFIC_FLASH_EN
    if (flash) w_nxt = S_FLASH;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_AR21;
      r_presc  <= '0;
      r_timer  <= LD_AR;
      r_lamps  <= 6'b001_001;
      r_req    <= 1'b0;
      r_g1_min <= 1'b0;
    end else begin
      if (w_chg) begin
        r_state  <= w_nxt;
        r_presc  <= '0;
        r_timer  <= load_of(w_nxt);
        r_lamps  <= lamps_of(w_nxt);
        r_g1_min <= 1'b0;
      end else begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick && (r_timer != '0)) r_timer <= r_timer - 1'b1;
        if ((r_state == S_G1) && w_expired) r_g1_min <= 1'b1;
`ifdef TRAFFIC_FLASH_EN
        if ((r_state == S_FLASH) && w_tick) r_lamps <= r_lamps ^ 6'b010_001;
`endif
      end

      // Clear on G2 entry takes priority over a simultaneous sensor hit
      if ((w_nxt == S_G2) && (r_state != S_G2)) begin
        r_req <= 1'b0;
`ifdef TRAFFIC_FLASH_EN
      end else if (s2 && (r_state != S_G2) && (r_state != S_FLASH)) begin
`else
      end else if (s2 && (r_state != S_G2)) begin
`endif
        r_req <= 1'b1;
      end
    end
  end

  assign {g1, y1, r1, g2, y2, r2} = r_lamps;
  assign phase    = r_state;
  assign req_pend = r_req;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Randomized bench for traffic_ctrl against a cycle-count reference model of the phase rules.
// Define TRAFFIC_FLASH_EN for both files to also exercise flash episodes.
`timescale 1ns/1ps
module tb_traffic_ctrl;
  localparam int TICK_DIV = 4;
  localparam int GREEN1_T = 3;
  localparam int GREEN2_T = 2;
  localparam int YELLOW_T = 2;
  localparam int ALLRED_T = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s2_v;
  logic       flash_v;
  logic       g1, y1, r1, g2, y2, r2;
  logic [2:0] phase;
  logic       req_pend;

  int n_chk  = 0;
  int n_fail = 0;

  int m_st;
  int m_cnt;
  bit m_req;

  traffic_ctrl #(
    .TICK_DIV(TICK_DIV), .TW(8), .GREEN1_T(GREEN1_T), .GREEN2_T(GREEN2_T),
    .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s2(s2_v),
`ifdef TRAFFIC_FLASH_EN
    .flash(flash_v),
`endif
    .g1(g1), .y1(y1), .r1(r1), .g2(g2), .y2(y2), .r2(r2),
    .phase(phase), .req_pend(req_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Dwell in clk cycles of each timed phase (0..5)
  function automatic int dwell(input int st);
    case (st)
      0:       return GREEN1_T * TICK_DIV;
      1, 4:    return YELLOW_T * TICK_DIV;
      3:       return GREEN2_T * TICK_DIV;
      default: return ALLRED_T * TICK_DIV;
    endcase
  endfunction

  function automatic logic [5:0] exp_lamps(input int st, input int cnt);
    bit f;
    case (st)
      0: return 6'b100_001;
      1: return 6'b010_001;
      3: return 6'b001_100;
      4: return 6'b001_010;
      6: begin
        f = ((cnt / TICK_DIV) % 2) == 0;
        return {1'b0, f, 1'b0, 1'b0, 1'b0, f};
      end
      default: return 6'b001_001;
    endcase
  endfunction

  task automatic model_reset();
    m_st = 5; m_cnt = 0; m_req = 0;
  endtask

  // Advance the model across one rising edge using the inputs now applied
  task automatic model_step();
    int nxt;
    nxt = m_st;
    if (m_st == 0) begin
      if ((m_cnt + 1 >= dwell(0)) && m_req) nxt = 1;
    end else if (m_st == 6) begin
      if (!flash_v) nxt = 5;
    end else if (m_cnt + 1 == dwell(m_st)) begin
      nxt = (m_st + 1) % 6;
    end
    if (flash_v) nxt = 6;
    if (nxt == 3 && m_st != 3) m_req = 0;
    else if (s2_v && m_st != 3 && m_st != 6) m_req = 1;
    if (nxt != m_st) begin
      m_st = nxt; m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, "_st"}, {23'd0, phase, g1, y1, r1, g2, y2, r2},
        {23'd0, m_st[2:0], exp_lamps(m_st, m_cnt)});
    chk({tag, "_req"}, {31'd0, req_pend}, {31'd0, m_req});
    chk({tag, "_excl"}, {31'd0, (g1 | y1) & (g2 | y2)}, 32'd0);
  endtask

  task automatic cycle(input bit s, input bit f, input string tag);
    s2_v = s;
    flash_v = f;
    model_step();
    @(negedge clk);
    compare(tag);
  endtask

  initial begin
    bit fl;
    int guard;
    rst_n = 1'b0; s2_v = 1'b0; flash_v = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compare("rst");
    rst_n = 1'b1;

    repeat (200) cycle(1'b0, 1'b0, "idle");
    chk("idle_g1", {29'd0, phase}, 32'd0);

    repeat (600) cycle(($urandom_range(0, 15) == 0), 1'b0, "rnd");

    repeat (150) cycle(1'b1, 1'b0, "hold");

    guard = 0;
    while (m_st != 3 && guard < 200) begin
      cycle(1'b1, 1'b0, "to_g2");
      guard++;
    end
    chk("reach_g2", {29'd0, phase}, 32'd3);
    cycle(1'b0, 1'b0, "in_g2");
    rst_n = 1'b0;
    #1;
    chk("async_rst", {26'd0, phase, g1, y1, r1, g2, y2, r2}, {26'd0, 3'd5, 6'b001_001});
    model_reset();
    @(negedge clk);
    compare("rst_hold");
    rst_n = 1'b1;
    repeat (4) cycle(1'b0, 1'b0, "restart");
    chk("restart_g1", {29'd0, phase}, 32'd0);

    fl = 1'b0;
    repeat (600) begin
`ifdef TRAFFIC_FLASH_EN
      if ($urandom_range(0, 40) == 0) fl = ~fl;
`endif
      cycle(($urandom_range(0, 7) == 0), fl, "rnd2");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
